// File: rtl/ol_sw_rx.sv
// Receive-side link monitor: word classification, lock FSM, peer LIVE and byte-swap detection.
// Define OL_SW_RX_ERRCNT_EN to add the saturating err_cnt output.
module ol_sw_rx #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int LIVE_CNT   = 8,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      rx_data,
    input  logic [1:0]       rx_datak,
    output logic             locked,
    output logic             peer_live,
    output logic             byte_swap,
    output logic [15:0]      data_out,
    output logic             data_valid,
    output logic             err_pulse
`ifdef OL_SW_RX_ERRCNT_EN
    ,
    output logic [ERR_W-1:0] err_cnt
`endif
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam int LW = $clog2(LIVE_CNT + 1);
    localparam logic [GW-1:0] LOCK_V   = GW'(LOCK_CNT);
    localparam logic [BW-1:0] UNLOCK_V = BW'(UNLOCK_CNT);
    localparam logic [LW-1:0] LIVE_V   = LW'(LIVE_CNT);

    typedef enum logic [1:0] {UNLOCKED, HUNT, LOCKED} state_e;
    typedef enum logic [2:0] {C_IDLE, C_LIVE, C_SWAP, C_PAY, C_BAD} cls_e;

    logic [15:0]   d1_q;
    logic [1:0]    k1_q;
    state_e        state_q, state_d;
    logic [GW-1:0] good_q, good_d, swap_q, swap_d;
    logic [BW-1:0] bad_q, bad_d;
    logic [LW-1:0] live_q, live_d;
    logic          locked_q, locked_d, peer_q, peer_d, bswap_q, bswap_d;
    logic [15:0]   dout_q, dout_d;
    logic          dv_q, dv_d, ep_q, ep_d;
    cls_e          cls;
    logic          is_err;

    always_comb begin
        cls = C_BAD;
        if (k1_q == 2'b11 && d1_q == 16'h50BC)      cls = C_IDLE;
        else if (k1_q == 2'b00 && d1_q == 16'h50BC) cls = C_LIVE;
        else if (k1_q == 2'b11 && d1_q == 16'hBC50) cls = C_SWAP;
        else if (k1_q == 2'b00)                     cls = C_PAY;
    end

    assign is_err = (cls == C_BAD) || (cls == C_SWAP);

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        swap_d   = swap_q;
        bad_d    = bad_q;
        live_d   = live_q;
        locked_d = locked_q;
        peer_d   = peer_q;
        bswap_d  = bswap_q;
        dout_d   = dout_q;
        dv_d     = 1'b0;
        ep_d     = 1'b0;

        // Swap hunting runs only while unlocked; the lock transition below clears byte_swap.
        if (state_q != LOCKED && cls == C_SWAP) begin
            if (swap_q != LOCK_V) swap_d = swap_q + 1'b1;
            if (swap_q + 1'b1 >= LOCK_V) bswap_d = 1'b1;
        end else begin
            swap_d = '0;
        end

        unique case (state_q)
            UNLOCKED: begin
                good_d = '0;
                if (cls == C_IDLE) begin
                    state_d = HUNT;
                    good_d  = GW'(1);
                end
            end
            HUNT: begin
                if (cls == C_IDLE) begin
                    if (good_q + 1'b1 == LOCK_V) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                        bswap_d  = 1'b0;
                        good_d   = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end else begin
                    state_d = UNLOCKED;
                    good_d  = '0;
                end
            end
            LOCKED: begin
                if (is_err) begin
                    ep_d   = 1'b1;
                    live_d = '0;
                    if (bad_q + 1'b1 == UNLOCK_V) begin
                        state_d  = UNLOCKED;
                        locked_d = 1'b0;
                        peer_d   = 1'b0;
                        bad_d    = '0;
                    end else begin
                        bad_d = bad_q + 1'b1;
                    end
                end else begin
                    bad_d = '0;
                    if (cls == C_IDLE) begin
                        live_d = '0;
                        peer_d = 1'b0;
                    end else if (cls == C_LIVE) begin
                        if (live_q != LIVE_V) live_d = live_q + 1'b1;
                        if (live_q + 1'b1 >= LIVE_V) peer_d = 1'b1;
                    end else if (peer_q) begin
                        dout_d = d1_q;
                        dv_d   = 1'b1;
                    end
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_q     <= '0;
            k1_q     <= '0;
            state_q  <= UNLOCKED;
            good_q   <= '0;
            swap_q   <= '0;
            bad_q    <= '0;
            live_q   <= '0;
            locked_q <= 1'b0;
            peer_q   <= 1'b0;
            bswap_q  <= 1'b0;
            dout_q   <= '0;
            dv_q     <= 1'b0;
            ep_q     <= 1'b0;
        end else begin
            d1_q     <= rx_data;
            k1_q     <= rx_datak;
            state_q  <= state_d;
            good_q   <= good_d;
            swap_q   <= swap_d;
            bad_q    <= bad_d;
            live_q   <= live_d;
            locked_q <= locked_d;
            peer_q   <= peer_d;
            bswap_q  <= bswap_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
            ep_q     <= ep_d;
        end
    end

`ifdef OL_SW_RX_ERRCNT_EN
    logic [ERR_W-1:0] ec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ec_q <= '0;
        else if (ep_d && ec_q != '1) ec_q <= ec_q + 1'b1;
    end

    assign err_cnt = ec_q;
`endif

    assign locked     = locked_q;
    assign peer_live  = peer_q;
    assign byte_swap  = bswap_q;
    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign err_pulse  = ep_q;
endmodule

// File: tb/tb_ol_sw_rx.sv
// Directed table-driven bench for ol_sw_rx.
// Build with OL_SW_RX_ERRCNT_EN defined to also check err_cnt.
module tb_ol_sw_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rx_data = '0;
    logic [1:0]  rx_datak = '0;
    logic        locked, peer_live, byte_swap, data_valid, err_pulse;
    logic [15:0] data_out;
    logic [15:0] ec_act;
`ifdef OL_SW_RX_ERRCNT_EN
    logic [15:0] err_cnt;
    assign ec_act = err_cnt;
`else
    assign ec_act = '0;
`endif

    ol_sw_rx dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_datak(rx_datak),
        .locked(locked), .peer_live(peer_live), .byte_swap(byte_swap),
        .data_out(data_out), .data_valid(data_valid), .err_pulse(err_pulse)
`ifdef OL_SW_RX_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rs;
        logic [15:0] d;
        logic [1:0]  k;
        logic        lk, pl, bs, dv, ep;
        logic [15:0] dout;
        logic [15:0] ec;
    } vec_t;

    vec_t tv[$];
    vec_t pend;
    bit   have_pend = 0;
    int   pend_idx = 0;
    int   total = 0;
    int   bad = 0;

    function automatic vec_t mk(bit rs, logic [15:0] d, logic [1:0] k,
                                logic lk, logic pl, logic bs, logic dv,
                                logic [15:0] dout, logic ep, logic [15:0] ec);
        vec_t v;
        v.rs = rs; v.d = d; v.k = k; v.lk = lk; v.pl = pl; v.bs = bs;
        v.dv = dv; v.dout = dout; v.ep = ep; v.ec = ec;
        return v;
    endfunction

    task automatic add_n(int n, logic [15:0] d, logic [1:0] k, logic lk,
                         logic pl, logic bs, logic [15:0] dout, logic [15:0] ec);
        for (int i = 0; i < n; i++) tv.push_back(mk(0, d, k, lk, pl, bs, 0, dout, 0, ec));
    endtask

    task automatic cmp(string nm, int idx, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    task automatic check(vec_t e, int idx);
        cmp("locked", idx, 16'(locked), 16'(e.lk));
        cmp("peer_live", idx, 16'(peer_live), 16'(e.pl));
        cmp("byte_swap", idx, 16'(byte_swap), 16'(e.bs));
        cmp("data_valid", idx, 16'(data_valid), 16'(e.dv));
        cmp("data_out", idx, data_out, e.dout);
        cmp("err_pulse", idx, 16'(err_pulse), 16'(e.ep));
`ifdef OL_SW_RX_ERRCNT_EN
        cmp("err_cnt", idx, ec_act, e.ec);
`endif
    endtask

    task automatic step(vec_t v, int idx);
        rx_data = v.d;
        rx_datak = v.k;
        @(posedge clk);
        #1;
        if (have_pend) check(pend, pend_idx);
        pend = v;
        pend_idx = idx;
        have_pend = 1;
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        if (have_pend) check(pend, pend_idx);
        have_pend = 0;
    endtask

    task automatic do_reset(int idx);
        rx_data = '0;
        rx_datak = '0;
        rst = 1'b1;
        #1;
        check(mk(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0), 1000 + idx);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        vec_t z;
        // Scenario A: lock, live, payload, errors, unlock
        tv.push_back(mk(1, 16'h50BC, 2'b11, 0, 0, 0, 0, 16'h0, 0, 0));
        add_n(14, 16'h50BC, 2'b11, 0, 0, 0, 16'h0, 0);
        add_n(1, 16'h50BC, 2'b11, 1, 0, 0, 16'h0, 0);
        add_n(7, 16'h50BC, 2'b00, 1, 0, 0, 16'h0, 0);
        add_n(1, 16'h50BC, 2'b00, 1, 1, 0, 16'h0, 0);
        tv.push_back(mk(0, 16'h1234, 2'b00, 1, 1, 0, 1, 16'h1234, 0, 0));
        add_n(1, 16'h50BC, 2'b00, 1, 1, 0, 16'h1234, 0);
        add_n(1, 16'h50BC, 2'b11, 1, 0, 0, 16'h1234, 0);
        for (int i = 1; i <= 3; i++)
            tv.push_back(mk(0, 16'h0000, 2'b01, 1, 0, 0, 0, 16'h1234, 1, 16'(i)));
        add_n(1, 16'h50BC, 2'b11, 1, 0, 0, 16'h1234, 3);
        add_n(7, 16'h50BC, 2'b00, 1, 0, 0, 16'h1234, 3);
        add_n(1, 16'h50BC, 2'b00, 1, 1, 0, 16'h1234, 3);
        for (int i = 4; i <= 6; i++)
            tv.push_back(mk(0, 16'h0000, 2'b01, 1, 1, 0, 0, 16'h1234, 1, 16'(i)));
        tv.push_back(mk(0, 16'h0000, 2'b01, 0, 0, 0, 0, 16'h1234, 1, 7));
        add_n(1, 16'h5555, 2'b00, 0, 0, 0, 16'h1234, 7);
        // Scenario B: byte swap, then lock clears it, in-lock error kinds
        tv.push_back(mk(1, 16'hBC50, 2'b11, 0, 0, 0, 0, 16'h0, 0, 0));
        add_n(14, 16'hBC50, 2'b11, 0, 0, 0, 16'h0, 0);
        add_n(2, 16'hBC50, 2'b11, 0, 0, 1, 16'h0, 0);
        add_n(15, 16'h50BC, 2'b11, 0, 0, 1, 16'h0, 0);
        add_n(1, 16'h50BC, 2'b11, 1, 0, 0, 16'h0, 0);
        tv.push_back(mk(0, 16'hBC50, 2'b11, 1, 0, 0, 0, 16'h0, 1, 1));
        tv.push_back(mk(0, 16'h1111, 2'b11, 1, 0, 0, 0, 16'h0, 1, 2));
        tv.push_back(mk(0, 16'h50BC, 2'b10, 1, 0, 0, 0, 16'h0, 1, 3));
        add_n(1, 16'h50BC, 2'b11, 1, 0, 0, 16'h0, 3);
        add_n(1, 16'hABCD, 2'b00, 1, 0, 0, 16'h0, 3);
        // Scenario C: HUNT broken by LIVE_MK, relock, payload stream
        tv.push_back(mk(1, 16'h50BC, 2'b11, 0, 0, 0, 0, 16'h0, 0, 0));
        add_n(9, 16'h50BC, 2'b11, 0, 0, 0, 16'h0, 0);
        add_n(1, 16'h50BC, 2'b00, 0, 0, 0, 16'h0, 0);
        add_n(15, 16'h50BC, 2'b11, 0, 0, 0, 16'h0, 0);
        add_n(1, 16'h50BC, 2'b11, 1, 0, 0, 16'h0, 0);
        add_n(7, 16'h50BC, 2'b00, 1, 0, 0, 16'h0, 0);
        add_n(1, 16'h50BC, 2'b00, 1, 1, 0, 16'h0, 0);
        tv.push_back(mk(0, 16'h0F0F, 2'b00, 1, 1, 0, 1, 16'h0F0F, 0, 0));
        tv.push_back(mk(0, 16'hF0F0, 2'b00, 1, 1, 0, 1, 16'hF0F0, 0, 0));

        foreach (tv[i]) begin
            if (tv[i].rs) begin
                if (have_pend) drain();
                do_reset(i);
            end
            step(tv[i], i);
        end

        // Async reset in the middle of a payload stream
        step(mk(0, 16'h7777, 2'b00, 1, 1, 0, 1, 16'h7777, 0, 0), 2000);
        drain();
        #2;
        rst = 1'b1;
        #1;
        z = mk(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
        check(z, 2001);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 15; i++)
            step(mk(0, 16'h50BC, 2'b11, 0, 0, 0, 0, 16'h0, 0, 0), 2100 + i);
        step(mk(0, 16'h50BC, 2'b11, 1, 0, 0, 0, 16'h0, 0, 0), 2115);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ol_sw_rx.md
# ol_sw_rx

Receive-side link monitor for the 16-bit optical link driven by the link transmitter. The transmitter sends the idle word 0x50BC with datak=2'b11 while not LIVE and with datak=2'b00 while LIVE. This block sits after the transceiver's 8b/10b decoder. It:
- classifies every received word;
- acquires and holds word lock;
- reports the peer's LIVE state and byte-swap misalignment;
- forwards non-idle payload words once the link is locked and the peer is live.

## Interface
Parameters:
- LOCK_CNT, 16: consecutive IDLE words required to acquire lock (also the consecutive SWAP words required to set byte_swap).
- UNLOCK_CNT, 4: consecutive error words that drop lock.
- LIVE_CNT, 8: consecutive LIVE_MK words that assert peer_live.
- ERR_W, 16: err_cnt width.

Ports:
- clk  in  1  link word clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  16  decoded word from transceiver.
- rx_datak  in  2  per-byte K flags (bit1 = high byte).
- locked  out  1  word lock held.
- peer_live  out  1  far end reports LIVE.
- byte_swap  out  1  stream is byte-swapped (0xBC50 K pattern).
- data_out  out  16  forwarded payload word.
- data_valid  out  1  data_out valid this cycle.
- err_pulse  out  1  one-cycle strobe per error word while locked.
- err_cnt  out  ERR_W  saturating error count (present only with OL_SW_RX_ERRCNT_EN).

## Operation
- Stage 1 registers rx_data/rx_datak; the reset value is 0x0000/2'b00.
- Stage 2 classifies the registered word. The FSM and all outputs update from that class.
- Word classes:
  - IDLE = 0x50BC/2'b11.
  - LIVE_MK = 0x50BC/2'b00.
  - SWAP = 0xBC50/2'b11.
  - PAYLOAD = datak 2'b00 with data ≠ 0x50BC.
  - BAD = everything else (datak 01/10, or datak 11 with other data).
- Error word = BAD or SWAP.
- FSM states: UNLOCKED, HUNT, LOCKED.
  - UNLOCKED: IDLE → HUNT with good_cnt=1. Anything else → stay.
  - HUNT: IDLE increments good_cnt; reaching LOCK_CNT → LOCKED (locked=1). Any non-IDLE → UNLOCKED with good_cnt=0.
  - LOCKED: IDLE, LIVE_MK or PAYLOAD clears bad_cnt. An error word increments bad_cnt and pulses err_pulse; reaching UNLOCK_CNT → UNLOCKED (locked=0, peer_live=0, bad_cnt=0).
- peer_live applies only in LOCKED:
  - consecutive LIVE_MK words count up; at LIVE_CNT, peer_live=1;
  - PAYLOAD neither resets the count nor clears peer_live;
  - IDLE or an error word resets the count;
  - IDLE also clears peer_live at once.
- byte_swap:
  - in UNLOCKED/HUNT, consecutive SWAP words count up; at LOCK_CNT, byte_swap=1;
  - any other word resets that count;
  - byte_swap is sticky until the transition into LOCKED (cleared there) or reset.
- Payload forwarding: a PAYLOAD word classified while LOCKED with peer_live=1 loads data_out and sets data_valid=1 for one cycle. Otherwise data_valid=0 and data_out holds.
- Counters saturate at their thresholds; there is no wrap-around.

## Timing
- Reset values: locked=0, peer_live=0, byte_swap=0, data_out=0, data_valid=0, err_pulse=0, err_cnt=0. The FSM is in UNLOCKED and all counters are 0.
- Reset asserts asynchronously. Outputs clear without a clock edge, including mid-lock or mid-payload.
- Latency is 2 clocks from a word at the rx input edge to its effect on the outputs.
  - Example: IDLE words sampled at edges 1..16 give locked=1 after edge 17.
  - Example: a PAYLOAD word sampled at edge k gives data_valid=1 after edge k+1.
- Same-word precedence in LOCKED: an error word that reaches UNLOCK_CNT still pulses err_pulse in the same cycle that locked falls.
- peer_live falls in the same cycle an IDLE word is classified. No data_valid is issued for that word.

## Configuration
- OL_SW_RX_ERRCNT_EN defined:
  - err_cnt port and an ERR_W-bit counter exist;
  - the counter increments on every err_pulse and saturates at all-ones;
  - it is cleared only by rst.
- Undefined: err_cnt port and counter are absent. err_pulse and all other behaviour are unchanged.

## Test plan
- rst, then 16 × 0x50BC/11 → locked=1 after the 17th edge; peer_live=0, byte_swap=0, data_valid=0 throughout.
- Locked, 8 × 0x50BC/00 → peer_live=1. Then 0x1234/00 → data_out=0x1234, data_valid=1 for exactly 1 cycle. Then 0x50BC/11 → peer_live=0.
- Locked: 3 × 0x0000/01, then IDLE → locked stays 1, 3 err_pulses, err_cnt=3 (macro on). Then 4 × 0x0000/01 → locked=0, peer_live=0, err_cnt=7.
- rst, 16 × 0xBC50/11 → byte_swap=1, locked=0. Then 16 × 0x50BC/11 → locked=1, byte_swap=0.
- HUNT after 10 IDLE, then 1 × 0x50BC/00 → UNLOCKED. A further 15 IDLE gives locked=0; the 16th IDLE gives locked=1.
- Locked with peer_live=1 and a payload streaming, assert rst between edges → all outputs 0 immediately. After release, lock requires 16 fresh IDLE words.
